// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the 16-point FFT/IFFT datapath.
package fft_pkg;

  localparam int N     = 16;
  localparam int LOG2N = 4;

  // Q1.14 twiddles for k = 0..7 of a 16-point transform; an IFFT uses +sin.
  localparam int TW_COS [8] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
  localparam int TW_SIN [8] = '{0, 6270, 11585, 15137, 16384, 15137, 11585, 6270};

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } state_t;

  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/ifft_butterfly.sv
// Combinational radix-2 butterfly: a' = sat((a + W*b) >> 1), b' = sat((a - W*b) >> 1).
// Macro IFFT_16_ROUND_EN selects round-half-up on the >>1 (default: floor).
module ifft_butterfly #(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  logic signed [TW-1:0] w_re,
  input  logic signed [TW-1:0] w_im,
  output logic signed [DW-1:0] p_re,
  output logic signed [DW-1:0] p_im,
  output logic signed [DW-1:0] q_re,
  output logic signed [DW-1:0] q_im
);

  localparam int PW = DW + TW + 1;
  localparam int SW = DW + 2;
  localparam logic signed [SW-1:0] MAX_V = SW'((1 <<< (DW - 1)) - 1);
  localparam logic signed [SW-1:0] MIN_V = SW'(-(1 <<< (DW - 1)));
`ifdef IFFT_16_ROUND_EN
  localparam logic signed [SW-1:0] RND = SW'(1);
`else
  localparam logic signed [SW-1:0] RND = SW'(0);
`endif

  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > MAX_V) return MAX_V[DW-1:0];
    if (v < MIN_V) return MIN_V[DW-1:0];
    return v[DW-1:0];
  endfunction

  logic signed [PW-1:0] m_re, m_im;
  logic signed [SW-1:0] wb_re, wb_im;
  logic signed [SW-1:0] sp_re, sp_im, sq_re, sq_im;

  always_comb begin
    m_re  = PW'(w_re) * PW'(b_re) - PW'(w_im) * PW'(b_im);
    m_im  = PW'(w_re) * PW'(b_im) + PW'(w_im) * PW'(b_re);
    // |W*b| <= sqrt(2)*2^(DW-1), so the truncated product always fits SW bits.
    wb_re = SW'(m_re >>> (TW - 2));
    wb_im = SW'(m_im >>> (TW - 2));
    sp_re = (SW'(a_re) + wb_re + RND) >>> 1;
    sp_im = (SW'(a_im) + wb_im + RND) >>> 1;
    sq_re = (SW'(a_re) - wb_re + RND) >>> 1;
    sq_im = (SW'(a_im) - wb_im + RND) >>> 1;
    p_re  = sat(sp_re);
    p_im  = sat(sp_im);
    q_re  = sat(sq_re);
    q_im  = sat(sq_im);
  end

endmodule

// File: rtl/ifft_16.sv
// 16-point radix-2 DIT inverse FFT, in-place with one time-shared butterfly.
// Macro IFFT_16_ROUND_EN (in ifft_butterfly) enables per-stage rounding.
module ifft_16
  import fft_pkg::*;
#(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x_real,
  input  logic [DW-1:0] x_imag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] y_real,
  output logic [DW-1:0] y_imag,
  output logic          out_last,
  output logic          busy
);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [4:0] step;
  logic       armed;
  logic [1:0] stg;
  logic [2:0] bfy, low, tw_k;
  logic [3:0] addr_a, addr_b;
  logic       in_fire, out_fire;

  logic signed [DW-1:0] mem_re [N];
  logic signed [DW-1:0] mem_im [N];
  logic signed [DW-1:0] p_re, p_im, q_re, q_im;
  logic signed [TW-1:0] w_re, w_im;

  assign stg      = step[4:3];
  assign bfy      = step[2:0];
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (in_fire && cnt == 4'd15)   state_nxt = COMPUTE;
      COMPUTE: if (step == 5'd31)             state_nxt = UNLOAD;
      UNLOAD:  if (out_fire && cnt == 4'd15)  state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = armed && (state == LOAD);
    out_valid = (state == UNLOAD);
    out_last  = out_valid && (cnt == 4'd15);
    busy      = (state != LOAD);
    y_real    = out_valid ? mem_re[cnt] : '0;
    y_imag    = out_valid ? mem_im[cnt] : '0;
  end

  // cnt doubles as load index and unload index; both wrap to 0 on the 16th beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed <= 1'b0;
      cnt   <= '0;
      step  <= '0;
    end else begin
      armed <= 1'b1;
      if (in_fire || out_fire)  cnt  <= cnt + 4'd1;
      if (state == COMPUTE)     step <= step + 5'd1;
    end
  end

  // Butterfly addressing: a = (j/span)*2*span + j%span, b = a + span.
  always_comb begin
    low    = bfy & ((3'd1 << stg) - 3'd1);
    addr_a = 4'((4'(bfy) >> stg) << (3'(stg) + 3'd1)) | 4'(low);
    addr_b = addr_a | (4'd1 << stg);
    tw_k   = 3'(low << (3'd3 - 3'(stg)));
    w_re   = TW'(TW_COS[tw_k]);
    w_im   = TW'(TW_SIN[tw_k]);
  end

  ifft_butterfly #(.DW(DW), .TW(TW)) u_bfly (
    .a_re (mem_re[addr_a]),
    .a_im (mem_im[addr_a]),
    .b_re (mem_re[addr_b]),
    .b_im (mem_im[addr_b]),
    .w_re (w_re),
    .w_im (w_im),
    .p_re (p_re),
    .p_im (p_im),
    .q_re (q_re),
    .q_im (q_im)
  );

  // NOTE: the sample memory has no reset; every frame fully rewrites it before use.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_re[bitrev4(cnt)] <= x_real;
      mem_im[bitrev4(cnt)] <= x_imag;
    end else if (state == COMPUTE) begin
      mem_re[addr_a] <= p_re;
      mem_im[addr_a] <= p_im;
      mem_re[addr_b] <= q_re;
      mem_im[addr_b] <= q_im;
    end
  end

endmodule

// File: tb/tb_ifft_16.sv
// Directed self-checking bench for ifft_16: impulse, DC, tone, backpressure, reset, rounding.
module tb_ifft_16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x_real = '0;
  logic [15:0] x_imag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] y_real, y_imag;
  logic        out_last;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int fr_re [16];
  int fr_im [16];
  int ex_re [16];
  int ex_im [16];
  int cos_t [16] = '{1024, 946, 724, 392, 0, -392, -724, -946,
                     -1024, -946, -724, -392, 0, 392, 724, 946};
  int sin_t [16] = '{0, 392, 724, 946, 1024, 946, 724, 392,
                     0, -392, -724, -946, -1024, -946, -724, -392};

  ifft_16 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_real    (x_real),
    .x_imag    (x_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_real    (y_real),
    .y_imag    (y_imag),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp, input int tol = 0);
    n_tests++;
    if (got - exp > tol || exp - got > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic set_frame(input int k, input int re, input int exp_all);
    for (int i = 0; i < 16; i++) begin
      fr_re[i] = 0;
      fr_im[i] = 0;
      ex_re[i] = exp_all;
      ex_im[i] = 0;
    end
    fr_re[k] = re;
  endtask

  task automatic send_frame();
    int guard;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      x_real   = 16'(fr_re[i]);
      x_imag   = 16'(fr_im[i]);
      guard    = 0;
      while (!in_ready && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 200) begin
        check("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic recv_frame(input string name, input int tol, input int stall_at);
    int guard;
    int held_re, held_im;
    out_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      guard = 0;
      while (!out_valid && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 200) begin
        check({name, "_out_valid_timeout"}, 0, 1);
        return;
      end
      if (n == stall_at) begin
        out_ready = 1'b0;
        held_re   = $signed(y_real);
        held_im   = $signed(y_imag);
        repeat (5) begin
          @(posedge clk); #1;
          check({name, "_stall_valid"}, int'(out_valid), 1);
          check({name, "_stall_re"}, $signed(y_real), held_re);
          check({name, "_stall_im"}, $signed(y_imag), held_im);
        end
        out_ready = 1'b1;
      end
      check($sformatf("%s_re[%0d]", name, n), $signed(y_real), ex_re[n], tol);
      check($sformatf("%s_im[%0d]", name, n), $signed(y_imag), ex_im[n], tol);
      check($sformatf("%s_last[%0d]", name, n), int'(out_last), int'(n == 15));
      check($sformatf("%s_in_ready[%0d]", name, n), int'(in_ready), 0);
      @(posedge clk); #1;
    end
    check({name, "_in_ready_after"}, int'(in_ready), 1);
  endtask

  task automatic run_frame(input string name, input int tol, input int stall_at);
    int lat;
    send_frame();
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, 32);
    recv_frame(name, tol, stall_at);
  endtask

  initial begin
    #12;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_y_real", int'(y_real), 0);
    check("rst_y_imag", int'(y_imag), 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", int'(in_ready), 1);

    set_frame(0, 16'h1000, 16'h0100);
    run_frame("impulse", 0, -1);

    set_frame(0, 16'h1000, 0);
    for (int i = 0; i < 16; i++) fr_re[i] = 16'h1000;
    ex_re[0] = 16'h1000;
    run_frame("dc", 0, -1);

    set_frame(1, 16'h4000, 0);
    for (int i = 0; i < 16; i++) begin
      ex_re[i] = cos_t[i];
      ex_im[i] = sin_t[i];
    end
    run_frame("tone_bp", 2, 6);

    set_frame(0, 16'h1000, 16'h0100);
    run_frame("b2b_impulse", 0, -1);

    send_frame();
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy", int'(busy), 1);
    check("mid_in_ready", int'(in_ready), 0);
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_in_ready", int'(in_ready), 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_in_ready", int'(in_ready), 1);
    check("mid_rel_out_valid", int'(out_valid), 0);
    run_frame("post_rst_impulse", 0, -1);

`ifdef IFFT_16_ROUND_EN
    set_frame(0, 15, 1);
`else
    set_frame(0, 15, 0);
`endif
    run_frame("rounding", 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifft_16.md
# ifft_16

Radix-2 decimation-in-time 16-point inverse FFT for complex 16-bit samples, the inverse counterpart of `fft_16` in the 16-point transform datapath. It accepts one frequency-domain frame in natural order over a valid/ready stream and computes in place with a single time-shared butterfly. It then streams the 1/16-scaled time-domain frame out in natural order over a second valid/ready stream.

## Interface
- `DW`, 16: sample component width, two's complement.
- `TW`, 16: twiddle component width, Q1.14 (1.0 = 16384).
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset. Asserting it (low) clears all state immediately.
- `in_valid` in 1: input sample present.
- `in_ready` out 1: block can accept an input sample.
- `x_real`, `x_imag` in DW: input bin X[k], with k = arrival index 0..15.
- `out_valid` out 1: output sample present.
- `out_ready` in 1: downstream accepts the output sample.
- `y_real`, `y_imag` out DW: output sample y[n], n = 0..15.
- `out_last` out 1: high together with `out_valid` on n = 15.
- `busy` out 1: high in COMPUTE and UNLOAD.

## Operation
- **FSM LOAD**
  - `in_ready` = 1.
  - Each handshake (`in_valid & in_ready`) writes the sample to `mem[bitrev4(idx)]` and increments `idx`.
  - The handshake at idx = 15 moves the FSM to COMPUTE with `idx` = 0.
- **FSM COMPUTE**
  - 4 stages, s = 0..3, with 8 butterflies each, j = 0..7.
  - One butterfly per clock; 32 cycles total.
  - Index calculation:
    - span = 2^s.
    - a = (j / span)·2·span + (j mod span).
    - b = a + span.
    - Twiddle index k = (j mod span)·(8 >> s).
  - The butterfly reads `mem[a]` and `mem[b]` and writes both results back to the same addresses on the same edge.
  - After s = 3, j = 7 the FSM moves to UNLOAD.
- **FSM UNLOAD**
  - `out_valid` = 1, and `y` = `mem[n]`.
  - `n` advances on each `out_valid & out_ready` handshake.
  - The handshake at n = 15 returns the FSM to LOAD.
- **Butterfly**
  - Inverse twiddle W = cos(2πk/16) + j·sin(2πk/16), with a positive sine.
  - Complex product W·b uses full-precision products, arithmetic shift right by 14, and no rounding on the product.
  - a' = (a + W·b) >> 1 and b' = (a − W·b) >> 1, computed at DW+2 bits.
  - Results saturate to [−2^(DW−1), 2^(DW−1)−1].
- **Scaling:** the net gain is exactly 1/16, which is the IFFT normalisation.
- **Input stability:**
  - `x_*` is sampled only on a handshake.
  - `y_*`, `out_last` and `out_valid` are held stable while `out_valid & !out_ready`.
- **Reset values:**
  - `in_ready` = 0 while reset is asserted, and 1 in the first cycle after release.
  - `out_valid`, `out_last`, `busy` = 0.
  - `y_real`, `y_imag` = 0.
  - FSM in LOAD with `idx` = 0. Memory contents are don't-care.
- **Reset mid-operation (any state):** the partial frame is discarded, with no partial output.
- **Overlap:** there is no overlap between frames. `in_ready` = 0 throughout COMPUTE and UNLOAD.

## Timing
- If the 16th input handshake occurs at edge E0:
  - COMPUTE occupies edges E1..E32.
  - `out_valid` rises after E32, so the first output can be taken at E33.
- With `out_ready` held high, the frame unloads in 16 cycles.
- `in_ready` rises in the cycle after the 16th output handshake.
- Minimum frame period is 64 cycles: 16 load + 32 compute + 16 unload.

## Configuration
- Macro `IFFT_16_ROUND_EN` controls the per-stage >>1 scaling.
  - **Defined:** round-half-up, i.e. add 1 before the shift.
  - **Undefined:** truncation (floor).
- The twiddle product shift is always truncation.

## Structure
- Shared package `fft_pkg` holds:
  - N = 16 and LOG2N = 4.
  - The 8-entry Q1.14 cosine/sine twiddle constants.
  - The state enum LOAD/COMPUTE/UNLOAD.
  - The `bitrev4` function.
- One sub-module, `ifft_butterfly`: a combinational complex multiply, add/sub, scale and saturate, shareable with `fft_16` via twiddle sign.
- The FSM, counters and the 16×2×DW register memory are in `ifft_16`.

## Test plan
1. **Impulse:** X[0] = (0x1000, 0), all other bins 0.
   - Expect all 16 outputs (0x0100, 0), exact.
   - Expect `out_last` only on n = 15.
2. **DC:** all X[k] = (0x1000, 0).
   - Expect y[0] = (0x1000, 0) and y[1..15] = (0, 0), exact.
3. **Tone:** X[1] = (0x4000, 0), all other bins 0.
   - Expect y[n] ≈ 1024·(cos 2πn/16, sin 2πn/16) within ±2 LSB.
   - Expect y[4] ≈ (0, 0x0400) and y[8] ≈ (0xFC00, 0).
4. **Backpressure:**
   - Drop `out_ready` for 5 cycles at n = 6: `y` and `out_valid` stay stable, all 16 samples are delivered in order, and `in_ready` = 0 until after n = 15.
   - A second frame sent back-to-back is correct.
5. **Reset mid-compute:** assert `reset` low during COMPUTE.
   - `out_valid`, `busy` = 0 immediately, and `in_ready` = 1 in the first cycle after release.
   - Case 1 repeated afterwards passes.
6. **Rounding:** X[0] = (0x000F, 0), all other bins 0.
   - Without `IFFT_16_ROUND_EN`: all y = (0, 0).
   - With `IFFT_16_ROUND_EN`: all y = (1, 0).
